clock_step_ctrl: RTL

//   Run/halt/single-step sequencer placed between the clock/reset generator and the core.
//   - Holds the design reset until the PLL is locked and settled.
//   - Issues a registered clock-enable (ce) to the design: free-running with a selectable

---
 rtl/clock_step_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl: run/halt/single-step clock-enable sequencer with PLL-lock reset hold.
// Optional build macro: CYCLE_COUNTER_EN adds the 32-bit ce pulse counter on cycle_cnt;
// without it cycle_cnt is tied to zero.
module clock_step_ctrl #(
    parameter int unsigned RESET_CYCLES  = 1024,
    parameter int unsigned DEBOUNCE_BITS = 16,
    parameter bit          START_RUN     = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        pll_locked,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic [3:0]  div_sel,
    output logic        ce,
    output logic        resetn_out,
    output logic [1:0]  state,
    output logic [31:0] cycle_cnt
);

    localparam int unsigned SETTLE_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned DB_W     = DEBOUNCE_BITS;
    localparam int unsigned PRESC_W  = 16;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(RESET_CYCLES - 1);
    localparam logic [DB_W-1:0]     DB_MAX      = '1;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_HALT = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [PRESC_W-1:0]   presc_max;
    logic [3:0]           div_q;
    logic                 ce_q, ce_d;
    logic                 resetn_q, resetn_d;

    logic                 lock_s1, lock_s;
    logic [1:0]           btn_raw, btn_s1, btn_s2, btn_db, btn_ev;
    logic [DB_W-1:0]      db_cnt [2];
    logic                 ev_run, ev_step;

    assign btn_raw = {btn_step, btn_run};
    assign ev_run  = btn_ev[0];
    assign ev_step = btn_ev[1];

    // Terminal prescaler value for the selected gearbox ratio
    assign presc_max = PRESC_W'((17'd1 << div_sel) - 17'd1);

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lock_s1 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_s1 <= pll_locked;
            lock_s  <= lock_s1;
        end
    end

    // Button sync + debounce; btn_ev pulses once when the debounced level rises
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            btn_s1    <= '0;
            btn_s2    <= '0;
            btn_db    <= '0;
            btn_ev    <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            for (int i = 0; i < 2; i++) begin
                btn_ev[i] <= 1'b0;
                if (btn_s2[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    btn_db[i] <= btn_s2[i];
                    btn_ev[i] <= btn_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // State and registered-output flops; ce/resetn_out follow the next state
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_RST;
            settle_q <= '0;
            presc_q  <= '0;
            div_q    <= '0;
            ce_q     <= 1'b0;
            resetn_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            presc_q  <= presc_d;
            div_q    <= div_sel;
            ce_q     <= ce_d;
            resetn_q <= resetn_d;
        end
    end

    // Next-state logic; lock loss overrides everything, run beats step.
    // ce is registered from the prescaler terminal count, so the first pulse
    // lands 2^div_sel cycles after RUN entry.
    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        presc_d  = '0;
        ce_d     = 1'b0;
        if (!lock_s) begin
            state_d = ST_RST;
        end else begin
            case (state_q)
                ST_RST: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = START_RUN ? ST_RUN : ST_HALT;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end
                ST_HALT: begin
                    if (ev_run) begin
                        state_d = ST_RUN;
                    end else if (ev_step) begin
                        state_d = ST_STEP;
                        ce_d    = 1'b1;
                    end
                end
                ST_STEP: begin
                    state_d = ST_HALT;
                end
                ST_RUN: begin
                    if (ev_run) begin
                        state_d = ST_HALT;
                    end else if (div_sel != div_q) begin
                        presc_d = '0;
                    end else if (presc_q == presc_max) begin
                        ce_d    = 1'b1;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RST;
                end
            endcase
        end
        resetn_d = (state_d != ST_RST);
    end

    assign ce         = ce_q;
    assign resetn_out = resetn_q;
    assign state      = state_q;

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt_q;

    // Count ce pulses; cleared whenever the design is held in reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cycle_cnt_q <= '0;
        end else if (state_d == ST_RST) begin
            cycle_cnt_q <= '0;
        end else if (ce_d) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`else
    assign cycle_cnt = 32'd0;
`endif

endmodule
